// File: rtl/mossbauer_sweep_sequencer_if.sv
// Bundle of the sequencer's control, configuration and status signals.
//   master: drives start/stop/abort and the dwell/channel/sweep configuration,
//           observes busy, channel, ch_tick, sweep_start, done, sweep_count.
//   slave : the sequencer side of the same signals.
interface mossbauer_sweep_sequencer_if #(
  parameter int CH_W = 10,
  parameter int SW_W = 16
);
  logic            start;
  logic            stop;
  logic            abort;
  logic [31:0]     dwell_max;
  logic [CH_W-1:0] num_ch;
  logic [SW_W-1:0] num_sweeps;

  logic            busy;
  logic [CH_W-1:0] channel;
  logic            ch_tick;
  logic            sweep_start;
  logic            done;
  logic [SW_W-1:0] sweep_count;

  modport master (
    output start, stop, abort, dwell_max, num_ch, num_sweeps,
    input  busy, channel, ch_tick, sweep_start, done, sweep_count
  );

  modport slave (
    input  start, stop, abort, dwell_max, num_ch, num_sweeps,
    output busy, channel, ch_tick, sweep_start, done, sweep_count
  );
endinterface

// File: rtl/mossbauer_sweep_sequencer.sv
// Velocity-sweep channel timebase for the Mossbauer histogrammer (adc_clk domain).
// A dwell counter advances the channel index 0..num_ch; each full pass is one
// sweep, repeated num_sweeps times (0 = until stop/abort). Dwell and channel
// count are shadowed and reloaded only at sweep boundaries so a running sweep
// is never distorted; the sweep count is latched once per run.
// Ports:
//   adc_clk  - clock, all logic on rising edge
//   adc_rstn - asynchronous active-low reset
//   bus      - slave side of mossbauer_sweep_sequencer_if
//              (start/stop/abort, dwell_max/num_ch/num_sweeps in;
//               busy/channel/ch_tick/sweep_start/done/sweep_count out)
module mossbauer_sweep_sequencer #(
  parameter int CH_W = 10,
  parameter int SW_W = 16
) (
  input  logic                         adc_clk,
  input  logic                         adc_rstn,
  mossbauer_sweep_sequencer_if.slave   bus
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     counter_q, counter_d;
  logic [31:0]     dwell_s_q, dwell_s_d;
  logic [CH_W-1:0] num_ch_s_q, num_ch_s_d;
  logic [SW_W-1:0] num_sweeps_s_q, num_sweeps_s_d;
  logic            stop_pending_q, stop_pending_d;
  logic            busy_q, busy_d;
  logic [CH_W-1:0] channel_q, channel_d;
  logic            ch_tick_q, ch_tick_d;
  logic            sweep_start_q, sweep_start_d;
  logic            done_q, done_d;
  logic [SW_W-1:0] sweep_count_q, sweep_count_d;
  logic [SW_W-1:0] sweep_count_inc;

  assign sweep_count_inc = sweep_count_q + SW_W'(1);

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      state_q        <= IDLE;
      counter_q      <= '0;
      dwell_s_q      <= '0;
      num_ch_s_q     <= '0;
      num_sweeps_s_q <= '0;
      stop_pending_q <= 1'b0;
      busy_q         <= 1'b0;
      channel_q      <= '0;
      ch_tick_q      <= 1'b0;
      sweep_start_q  <= 1'b0;
      done_q         <= 1'b0;
      sweep_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      counter_q      <= counter_d;
      dwell_s_q      <= dwell_s_d;
      num_ch_s_q     <= num_ch_s_d;
      num_sweeps_s_q <= num_sweeps_s_d;
      stop_pending_q <= stop_pending_d;
      busy_q         <= busy_d;
      channel_q      <= channel_d;
      ch_tick_q      <= ch_tick_d;
      sweep_start_q  <= sweep_start_d;
      done_q         <= done_d;
      sweep_count_q  <= sweep_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    counter_d      = counter_q;
    dwell_s_d      = dwell_s_q;
    num_ch_s_d     = num_ch_s_q;
    num_sweeps_s_d = num_sweeps_s_q;
    stop_pending_d = stop_pending_q;
    busy_d         = busy_q;
    channel_d      = channel_q;
    sweep_count_d  = sweep_count_q;
    ch_tick_d      = 1'b0;
    sweep_start_d  = 1'b0;
    done_d         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop && !bus.abort) begin
          state_d        = RUN;
          busy_d         = 1'b1;
          channel_d      = '0;
          sweep_start_d  = 1'b1;
          sweep_count_d  = '0;
          counter_d      = '0;
          stop_pending_d = 1'b0;
          dwell_s_d      = bus.dwell_max;
          num_ch_s_d     = bus.num_ch;
          num_sweeps_s_d = bus.num_sweeps;
        end
      end

      RUN: begin
        if (bus.abort) begin
          // Abort wins over any tick or sweep end on the same edge.
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          channel_d = '0;
          counter_d = '0;
        end else begin
          if (bus.stop) begin
            stop_pending_d = 1'b1;
          end
          if (counter_q >= dwell_s_q) begin
            counter_d = '0;
            ch_tick_d = 1'b1;
            if (channel_q < num_ch_s_q) begin
              channel_d = channel_q + CH_W'(1);
            end else begin
              channel_d     = '0;
              sweep_count_d = sweep_count_inc;
              // A stop arriving on the sweep-end edge itself still ends here.
              if (stop_pending_q || bus.stop ||
                  (num_sweeps_s_q != '0 && sweep_count_inc == num_sweeps_s_q)) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                sweep_start_d = 1'b1;
                dwell_s_d     = bus.dwell_max;
                num_ch_s_d    = bus.num_ch;
              end
            end
          end else begin
            counter_d = counter_q + 32'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.channel     = channel_q;
  assign bus.ch_tick     = ch_tick_q;
  assign bus.sweep_start = sweep_start_q;
  assign bus.done        = done_q;
  assign bus.sweep_count = sweep_count_q;

endmodule

// File: tb/tb_mossbauer_sweep_sequencer.sv
// Bench for mossbauer_sweep_sequencer. Cycle k is the interval after clock edge
// k-1; an input "at cycle k" is sampled on edge k. The expected timeline is
// built from sweep/channel durations rather than a cycle-level state machine.
module tb_mossbauer_sweep_sequencer;
  localparam int CH_W  = 10;
  localparam int SW_W  = 16;
  localparam int NEVER = 100000;
  localparam int MAXC  = 400;

  logic adc_clk = 1'b0;
  logic adc_rstn = 1'b0;

  mossbauer_sweep_sequencer_if #(.CH_W(CH_W), .SW_W(SW_W)) bus ();

  mossbauer_sweep_sequencer #(.CH_W(CH_W), .SW_W(SW_W)) dut (
    .adc_clk  (adc_clk),
    .adc_rstn (adc_rstn),
    .bus      (bus)
  );

  always #5 adc_clk = ~adc_clk;

  int n_pass = 0;
  int n_total = 0;

  logic [29:0] exp_v [0:MAXC];
  logic [29:0] act_v [0:MAXC];

  function automatic logic [29:0] pack(input logic b, input int unsigned ch, input logic tk,
                                       input logic ss, input logic dn, input int unsigned cnt);
    logic [9:0]  c10;
    logic [15:0] c16;
    c10 = ch[9:0];
    c16 = cnt[15:0];
    return {b, c10, tk, ss, dn, c16};
  endfunction

  function automatic logic [29:0] observe();
    return {bus.busy, bus.channel, bus.ch_tick, bus.sweep_start, bus.done, bus.sweep_count};
  endfunction

  function automatic string fields(input logic [29:0] v);
    return $sformatf("busy=%0b ch=%0d tick=%0b ss=%0b done=%0b cnt=%0d",
                     v[29], v[28:19], v[18], v[17], v[16], v[15:0]);
  endfunction

  // Reference timeline: a run is a sequence of sweeps, each sweep num_ch+1
  // channels of dwell+1 cycles, with configuration taken at the sweep's start edge.
  function automatic void build_model(input int d0, input int n0, input int d1, input int n1,
                                      input int chg, input int nsw, input int stp,
                                      input int abrt, input int n);
    int t, d, m, sw_edge, cnt;
    bit ended, first;
    for (int c = 0; c <= n; c++) exp_v[c] = pack(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    t = 1; cnt = 0; sw_edge = 0; ended = 0; first = 1;
    while (!ended && t <= n) begin
      d = (sw_edge >= chg) ? d1 : d0;
      m = (sw_edge >= chg) ? n1 : n0;
      for (int ch = 0; ch <= m && !ended; ch++) begin
        for (int c = t; c <= t + d && c <= n; c++)
          exp_v[c] = pack(1'b1, ch, (c == t) && !first, (c == t) && (ch == 0), 1'b0, cnt);
        first = 0;
        if (abrt >= t && abrt <= t + d) begin
          for (int c = abrt + 1; c <= n; c++)
            exp_v[c] = pack(1'b0, 0, 1'b0, 1'b0, c == abrt + 1, cnt);
          ended = 1;
        end
        t = t + d + 1;
      end
      if (!ended) begin
        cnt = (cnt + 1) % 65536;
        if ((stp >= 1 && stp <= t - 1) || (nsw != 0 && cnt == nsw)) begin
          for (int c = t; c <= n; c++)
            exp_v[c] = pack(1'b0, 0, c == t, 1'b0, c == t, cnt);
          ended = 1;
        end else begin
          sw_edge = t - 1;
        end
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge adc_clk);
    bus.start = 1'b0; bus.stop = 1'b0; bus.abort = 1'b0;
    adc_rstn = 1'b0;
    @(posedge adc_clk);
    @(negedge adc_clk);
    adc_rstn = 1'b1;
  endtask

  // Reset, then start on edge 0 and record outputs for cycles 1..n.
  task automatic run_stim(input int d0, input int n0, input int d1, input int n1,
                          input int chg, input int nsw, input int stp, input int abrt,
                          input int xstart, input int n);
    do_reset();
    bus.num_sweeps = nsw[SW_W-1:0];
    for (int e = 0; e < n; e++) begin
      bus.start     = (e == 0) || (e == xstart);
      bus.stop      = (e == stp);
      bus.abort     = (e == abrt);
      bus.dwell_max = (e >= chg) ? d1 : d0;
      bus.num_ch    = (e >= chg) ? n1[CH_W-1:0] : n0[CH_W-1:0];
      @(posedge adc_clk);
      @(negedge adc_clk);
      act_v[e + 1] = observe();
    end
    bus.start = 1'b0; bus.stop = 1'b0; bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    logic [29:0] v;
    bus.start = 1'b0; bus.stop = 1'b0; bus.abort = 1'b0;
    bus.dwell_max = 32'd3; bus.num_ch = '0; bus.num_sweeps = '0;
    adc_rstn = 1'b0;
    #1;
    v = observe();
    n_total++;
    if (v !== 30'd0) $display("FAIL reset_async: got %s, want all zero", fields(v));
    else n_pass++;
    @(posedge adc_clk);
    @(negedge adc_clk);
    v = observe();
    n_total++;
    if (v !== 30'd0) $display("FAIL reset_held: got %s, want all zero", fields(v));
    else n_pass++;
    adc_rstn = 1'b1;
  endtask

  task automatic test_basic();
    int ticks [6] = '{5, 9, 13, 17, 21, 25};
    run_stim(3, 2, 3, 2, NEVER, 2, NEVER, NEVER, NEVER, 30);
    build_model(3, 2, 3, 2, NEVER, 2, NEVER, NEVER, 30);
    for (int unsigned c = 1; c <= 30; c++) begin
      n_total++;
      if (act_v[c] !== exp_v[c])
        $display("FAIL basic cycle %0d: got %s, want %s", c, fields(act_v[c]), fields(exp_v[c]));
      else n_pass++;
    end
    foreach (ticks[i]) begin
      n_total++;
      if (act_v[ticks[i]][18] !== 1'b1)
        $display("FAIL basic_tick cycle %0d: got tick=%0b, want 1", ticks[i], act_v[ticks[i]][18]);
      else n_pass++;
    end
    n_total++;
    if (act_v[13][17] !== 1'b1 || act_v[1][17] !== 1'b1 || act_v[1][29] !== 1'b1)
      $display("FAIL basic_sweep_start: got c1=%s c13 ss=%0b, want busy/ss at 1, ss at 13",
               fields(act_v[1]), act_v[13][17]);
    else n_pass++;
    n_total++;
    if (act_v[25] !== pack(1'b0, 0, 1'b1, 1'b0, 1'b1, 2))
      $display("FAIL basic_done: got %s, want busy=0 ch=0 tick=1 done=1 cnt=2", fields(act_v[25]));
    else n_pass++;
  endtask

  task automatic test_stop();
    run_stim(3, 2, 3, 2, NEVER, 0, 7, NEVER, NEVER, 20);
    build_model(3, 2, 3, 2, NEVER, 0, 7, NEVER, 20);
    for (int unsigned c = 1; c <= 20; c++) begin
      n_total++;
      if (act_v[c] !== exp_v[c])
        $display("FAIL stop cycle %0d: got %s, want %s", c, fields(act_v[c]), fields(exp_v[c]));
      else n_pass++;
    end
    n_total++;
    if (act_v[13] !== pack(1'b0, 0, 1'b1, 1'b0, 1'b1, 1))
      $display("FAIL stop_done: got %s, want tick=1 ss=0 done=1 cnt=1", fields(act_v[13]));
    else n_pass++;
  endtask

  task automatic test_abort();
    run_stim(3, 2, 3, 2, NEVER, 2, NEVER, 10, NEVER, 16);
    build_model(3, 2, 3, 2, NEVER, 2, NEVER, 10, 16);
    for (int unsigned c = 1; c <= 16; c++) begin
      n_total++;
      if (act_v[c] !== exp_v[c])
        $display("FAIL abort cycle %0d: got %s, want %s", c, fields(act_v[c]), fields(exp_v[c]));
      else n_pass++;
    end
    n_total++;
    if (act_v[11] !== pack(1'b0, 0, 1'b0, 1'b0, 1'b1, 0))
      $display("FAIL abort_next: got %s, want busy=0 ch=0 tick=0 done=1 cnt=0", fields(act_v[11]));
    else n_pass++;
  endtask

  task automatic test_shadow();
    run_stim(3, 2, 1, 2, 3, 2, NEVER, NEVER, NEVER, 24);
    build_model(3, 2, 1, 2, 3, 2, NEVER, NEVER, 24);
    for (int unsigned c = 1; c <= 24; c++) begin
      n_total++;
      if (act_v[c] !== exp_v[c])
        $display("FAIL shadow cycle %0d: got %s, want %s", c, fields(act_v[c]), fields(exp_v[c]));
      else n_pass++;
    end
    n_total++;
    if (act_v[9][18] !== 1'b1 || act_v[15][18] !== 1'b1 || act_v[17][18] !== 1'b1 ||
        act_v[19][16] !== 1'b1 || act_v[7][18] !== 1'b0)
      $display("FAIL shadow_ticks: got t7=%0b t9=%0b t15=%0b t17=%0b done19=%0b, want 0 1 1 1 1",
               act_v[7][18], act_v[9][18], act_v[15][18], act_v[17][18], act_v[19][16]);
    else n_pass++;
  endtask

  task automatic test_single_channel();
    run_stim(0, 0, 0, 0, NEVER, 3, NEVER, NEVER, NEVER, 8);
    build_model(0, 0, 0, 0, NEVER, 3, NEVER, NEVER, 8);
    for (int unsigned c = 1; c <= 8; c++) begin
      n_total++;
      if (act_v[c] !== exp_v[c])
        $display("FAIL single_ch cycle %0d: got %s, want %s", c, fields(act_v[c]), fields(exp_v[c]));
      else n_pass++;
    end
  endtask

  task automatic test_start_in_run();
    run_stim(2, 1, 2, 1, NEVER, 1, NEVER, NEVER, 4, 12);
    build_model(2, 1, 2, 1, NEVER, 1, NEVER, NEVER, 12);
    for (int unsigned c = 1; c <= 12; c++) begin
      n_total++;
      if (act_v[c] !== exp_v[c])
        $display("FAIL start_in_run cycle %0d: got %s, want %s", c, fields(act_v[c]), fields(exp_v[c]));
      else n_pass++;
    end
  endtask

  task automatic test_idle_corners();
    logic [29:0] v;
    do_reset();
    bus.dwell_max = 32'd1; bus.num_ch = 10'd1; bus.num_sweeps = 16'd1;
    for (int unsigned k = 0; k < 2; k++) begin
      bus.start = 1'b1;
      bus.stop  = (k == 0);
      bus.abort = (k == 1);
      @(posedge adc_clk);
      @(negedge adc_clk);
      bus.start = 1'b0; bus.stop = 1'b0; bus.abort = 1'b0;
      @(posedge adc_clk);
      @(negedge adc_clk);
      v = observe();
      n_total++;
      if (v !== 30'd0)
        $display("FAIL idle_start_%s: got %s, want idle all zero", (k == 0) ? "stop" : "abort", fields(v));
      else n_pass++;
    end
  endtask

  task automatic test_reset_midrun();
    logic [29:0] v;
    do_reset();
    bus.dwell_max = 32'd1; bus.num_ch = 10'd3; bus.num_sweeps = 16'd0;
    bus.start = 1'b1;
    @(posedge adc_clk);
    @(negedge adc_clk);
    bus.start = 1'b0;
    repeat (5) begin
      @(posedge adc_clk);
      @(negedge adc_clk);
    end
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL rst_mid_busy: got busy=%0b, want 1", bus.busy);
    else n_pass++;
    #2;
    adc_rstn = 1'b0;
    #1;
    v = observe();
    n_total++;
    if (v !== 30'd0) $display("FAIL rst_mid_immediate: got %s, want all zero", fields(v));
    else n_pass++;
    @(posedge adc_clk);
    @(negedge adc_clk);
    adc_rstn = 1'b1;
    @(posedge adc_clk);
    @(negedge adc_clk);
    v = observe();
    n_total++;
    if (v !== 30'd0) $display("FAIL rst_mid_no_done: got %s, want all zero", fields(v));
    else n_pass++;
  endtask

  task automatic test_random();
    int d0, n0, d1, n1, chg, nsw, stp, abrt;
    for (int unsigned it = 0; it < 8; it++) begin
      d0   = $urandom_range(0, 4);
      n0   = $urandom_range(0, 3);
      d1   = $urandom_range(0, 4);
      n1   = $urandom_range(0, 3);
      chg  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40)) : NEVER;
      nsw  = $urandom_range(0, 3);
      stp  = (nsw == 0 || $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : NEVER;
      abrt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : NEVER;
      run_stim(d0, n0, d1, n1, chg, nsw, stp, abrt, NEVER, 130);
      build_model(d0, n0, d1, n1, chg, nsw, stp, abrt, 130);
      for (int unsigned c = 1; c <= 130; c++) begin
        n_total++;
        if (act_v[c] !== exp_v[c])
          $display("FAIL random%0d cycle %0d: got %s, want %s (d=%0d/%0d n=%0d/%0d chg=%0d nsw=%0d stp=%0d abrt=%0d)",
                   it, c, fields(act_v[c]), fields(exp_v[c]), d0, d1, n0, n1, chg, nsw, stp, abrt);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stop();
    test_abort();
    test_shadow();
    test_single_channel();
    test_start_in_run();
    test_idle_corners();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
